// File: rtl/mc2_joy_scan.sv
// mc2_joy_scan: DB9 joystick scanner with Mega Drive select handshake.
// Classifies each port and publishes a coherent active-low button word.
module mc2_joy_scan #(
  parameter int NUM_PORTS  = 2,
  parameter int STEP_DIV   = 192,
  parameter int IDLE_STEPS = 100
) (
  input  logic                      clk_i,
  input  logic                      res_n_i,
  input  logic                      enable_i,
  input  logic [NUM_PORTS-1:0]      atari_only_i,
  input  logic [NUM_PORTS-1:0]      joy_up_i,
  input  logic [NUM_PORTS-1:0]      joy_down_i,
  input  logic [NUM_PORTS-1:0]      joy_left_i,
  input  logic [NUM_PORTS-1:0]      joy_right_i,
  input  logic [NUM_PORTS-1:0]      joy_p6_i,
  input  logic [NUM_PORTS-1:0]      joy_p9_i,
  output logic                      joy_p7_o,
  output logic [12*NUM_PORTS-1:0]   joy_o,
  output logic [NUM_PORTS-1:0]      sixbtn_o,
  output logic                      valid_o
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int IW = (IDLE_STEPS > 1) ? $clog2(IDLE_STEPS) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PH0,
    S_PH1,
    S_PH2,
    S_PH3,
    S_PH4,
    S_PH5,
    S_PH6,
    S_PH7
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0] step_q;
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
  logic          sel_d;
  logic          phase_end;
  logic          idle_end;

  // per port pin bundle: {p9, p6, right, left, down, up}
  logic [NUM_PORTS-1:0][5:0] pin_raw;
  logic [NUM_PORTS-1:0][5:0] pin_s1;
  logic [NUM_PORTS-1:0][5:0] pin_s2;

  logic [NUM_PORTS-1:0][11:0] work_q;
  logic [NUM_PORTS-1:0]       md_q;
  logic [NUM_PORTS-1:0]       six_q;
  logic [NUM_PORTS-1:0]       md_now;
  logic [NUM_PORTS-1:0]       dirs_low;

  // gather raw pins into one bundle per port
  always_comb begin
    pin_raw = '1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pin_raw[p] = {joy_p9_i[p], joy_p6_i[p],
                    joy_right_i[p], joy_left_i[p],
                    joy_down_i[p], joy_up_i[p]};
    end
  end

  // two-flop synchronisers, idle-high
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      pin_s1 <= '1;
      pin_s2 <= '1;
    end else begin
      pin_s1 <= pin_raw;
      pin_s2 <= pin_s1;
    end
  end

  assign phase_end = (step_q == STEP_LAST);
  assign idle_end  = (idle_q == IDLE_LAST);

  // phase step counter, wraps on the last cycle of each phase
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      step_q <= '0;
    end else if (phase_end) begin
      step_q <= '0;
    end else begin
      step_q <= step_q + 1'b1;
    end
  end

  // state and idle-phase counter registers
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= S_IDLE;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end

  // next state: advance one phase per step, enable checked at idle end
  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    if (phase_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (idle_end) begin
            idle_d = '0;
            if (enable_i) begin
              state_d = S_PH0;
            end
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        S_PH0:   state_d = S_PH1;
        S_PH1:   state_d = S_PH2;
        S_PH2:   state_d = S_PH3;
        S_PH3:   state_d = S_PH4;
        S_PH4:   state_d = S_PH5;
        S_PH5:   state_d = S_PH6;
        S_PH6:   state_d = S_PH7;
        S_PH7:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // select level of the upcoming state: even phases low
  always_comb begin
    sel_d = 1'b1;
    case (state_d)
      S_PH0,
      S_PH2,
      S_PH4,
      S_PH6:   sel_d = 1'b0;
      default: sel_d = 1'b1;
    endcase
  end

  // registered select so the pin never glitches
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      joy_p7_o <= 1'b1;
    end else begin
      joy_p7_o <= sel_d;
    end
  end

  // pad signatures seen on the synchronised pins
  always_comb begin
    md_now   = '0;
    dirs_low = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      md_now[p]   = ~pin_s2[p][2] & ~pin_s2[p][3]
                  & ~atari_only_i[p];
      dirs_low[p] = (pin_s2[p][3:0] == 4'b0000);
    end
  end

  // working word capture at the end of the sampling phases
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      work_q <= '1;
      md_q   <= '0;
      six_q  <= '0;
    end else if (state_q == S_PH0) begin
      work_q <= '1;
      md_q   <= '0;
      six_q  <= '0;
    end else if (phase_end) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state_q)
          S_PH1: begin
            work_q[p][5:0] <= pin_s2[p];
          end
          S_PH2: begin
            md_q[p] <= md_now[p];
            if (md_now[p]) begin
              work_q[p][7:6] <= pin_s2[p][5:4];
            end
          end
          S_PH4: begin
            six_q[p] <= md_q[p] & dirs_low[p];
          end
          S_PH5: begin
            if (six_q[p]) begin
              work_q[p][11:8] <= pin_s2[p][3:0];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // publish all ports together at the end of the scan
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      joy_o    <= '1;
      sixbtn_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state_q == S_PH7 && phase_end) begin
        joy_o    <= work_q;
        sixbtn_o <= six_q;
        valid_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc2_joy_scan.sv
// tb_mc2_joy_scan: pad models drive the DUT, a scoreboard
// queue holds expected strobes, a monitor pops and compares.
module tb_mc2_joy_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  ao;
  logic [1:0]  j_up, j_dn, j_lt, j_rt, j_p6, j_p9;
  logic        joy_p7_o;
  logic [23:0] joy_o;
  logic [1:0]  sixbtn_o;
  logic        valid_o;

  mc2_joy_scan #(
    .NUM_PORTS  (2),
    .STEP_DIV   (4),
    .IDLE_STEPS (2)
  ) dut (
    .clk_i        (clk),
    .res_n_i      (rst_n),
    .enable_i     (en),
    .atari_only_i (ao),
    .joy_up_i     (j_up),
    .joy_down_i   (j_dn),
    .joy_left_i   (j_lt),
    .joy_right_i  (j_rt),
    .joy_p6_i     (j_p6),
    .joy_p9_i     (j_p9),
    .joy_p7_o     (joy_p7_o),
    .joy_o        (joy_o),
    .sixbtn_o     (sixbtn_o),
    .valid_o      (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since reset release
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // pad type: 0 none, 1 atari, 2 three-button, 3 six-button
  // btn: active-high pressed, bits M X Y Z S A C B R L D U
  int         ptype [2];
  logic [11:0] btn  [2];
  int         lc;
  int         hi_cnt;
  logic       p7_prev;

  // pad handshake counter: select lows since last long high
  initial begin
    lc      = 0;
    hi_cnt  = 0;
    p7_prev = 1'b1;
  end
  always @(negedge clk) begin
    if (joy_p7_o) begin
      if (hi_cnt < 100) hi_cnt = hi_cnt + 1;
      if (hi_cnt >= 6) lc = 0;
    end else begin
      if (p7_prev) lc = lc + 1;
      hi_cnt = 0;
    end
    p7_prev = joy_p7_o;
  end

  // returns {p9, p6, R, L, D, U}, active-low
  function automatic logic [5:0] pad_pins(
    input int t, input logic [11:0] b,
    input logic sel, input int l);
    logic [5:0] r;
    r = 6'h3F;
    if (t == 1) begin
      r = ~b[5:0];
    end else if (t == 2 || t == 3) begin
      if (sel) begin
        if (t == 3 && l == 3)
          r = {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]};
        else
          r = ~b[5:0];
      end else begin
        if (t == 3 && l == 3)
          r = {~b[7], ~b[6], 4'b0000};
        else if (t == 3 && l == 4)
          r = {~b[7], ~b[6], 4'b1111};
        else
          r = {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
      end
    end
    return r;
  endfunction

  logic [5:0] pins [2];
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pins[p] = pad_pins(ptype[p], btn[p], joy_p7_o, lc);
    end
  end
  assign j_up = {pins[1][0], pins[0][0]};
  assign j_dn = {pins[1][1], pins[0][1]};
  assign j_lt = {pins[1][2], pins[0][2]};
  assign j_rt = {pins[1][3], pins[0][3]};
  assign j_p6 = {pins[1][4], pins[0][4]};
  assign j_p9 = {pins[1][5], pins[0][5]};

  typedef struct {
    int          c;
    logic [23:0] joy;
    logic [1:0]  six;
  } exp_t;

  exp_t sb [$];
  int   checks;
  int   errors;
  int   seg;
  logic done;

  task automatic push_exp(input int c, input logic [23:0] j,
                          input logic [1:0] s);
    exp_t e;
    e.c   = c;
    e.joy = j;
    e.six = s;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h want=%h (t=%0t cyc=%0d)",
               nm, act, exp, $time, cyc);
    end
  endtask

  // monitor: strobes, holds, reset values, select timing
  logic [23:0] hold_joy;
  logic [1:0]  hold_six;
  exp_t        cur;
  initial begin
    checks   = 0;
    errors   = 0;
    hold_joy = 24'hFFFFFF;
    hold_six = 2'b00;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_joy", 32'(joy_o), 32'hFFFFFF);
      chk("rst_six", 32'(sixbtn_o), 32'h0);
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_p7", 32'(joy_p7_o), 32'h1);
      hold_joy = 24'hFFFFFF;
      hold_six = 2'b00;
    end else begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'(cyc), 32'hFFFFFFFF);
        end else begin
          cur = sb.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(cur.c));
          chk("strobe_joy", 32'(joy_o), 32'(cur.joy));
          chk("strobe_six", 32'(sixbtn_o), 32'(cur.six));
          hold_joy = cur.joy;
          hold_six = cur.six;
        end
      end else begin
        chk("hold_joy", 32'(joy_o), 32'(hold_joy));
        chk("hold_six", 32'(sixbtn_o), 32'(hold_six));
      end
      if (cyc == 7)  chk("p7_pre_ph0", 32'(joy_p7_o), 32'h1);
      if (cyc == 8)  chk("p7_ph0", 32'(joy_p7_o), 32'h0);
      if (seg == 0) begin
        if (cyc == 11) chk("p7_ph0_end", 32'(joy_p7_o), 32'h0);
        if (cyc == 12) chk("p7_ph1", 32'(joy_p7_o), 32'h1);
        if (cyc == 35) chk("p7_ph6", 32'(joy_p7_o), 32'h0);
        if (cyc == 36) chk("p7_ph7", 32'(joy_p7_o), 32'h1);
        if (cyc >= 240 && cyc <= 343)
          chk("p7_parked", 32'(joy_p7_o), 32'h1);
        if (cyc == 344) chk("p7_resume", 32'(joy_p7_o), 32'h0);
      end
    end
    if (done) begin
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    ao    = 2'b00;
    seg   = 0;
    done  = 1'b0;
    ptype[0] = 0; ptype[1] = 0;
    btn[0]   = '0; btn[1]  = '0;
    push_exp(40, 24'hFFFFFF, 2'b00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    wait_until(40);
    ptype[0] = 2; btn[0] = 12'h041;
    push_exp(80, {12'hFFF, 12'hFBE}, 2'b00);

    wait_until(80);
    ptype[0] = 1; btn[0] = 12'h014;
    ptype[1] = 3; btn[1] = 12'h480;
    push_exp(120, {12'hB7F, 12'hFEB}, 2'b10);

    wait_until(120);
    ao = 2'b10;
    push_exp(160, {12'hFFF, 12'hFEB}, 2'b00);

    wait_until(160);
    ao = 2'b00;
    ptype[0] = 2; btn[0] = 12'h00E;
    ptype[1] = 3; btn[1] = 12'h939;
    push_exp(200, {12'h6C6, 12'hFF1}, 2'b10);

    wait_until(200);
    push_exp(240, {12'h6C6, 12'hFF1}, 2'b10);

    wait_until(221);
    en = 1'b0;

    wait_until(340);
    en = 1'b1;
    ptype[0] = 0; btn[0] = '0;
    ptype[1] = 2; btn[1] = 12'h0A0;
    push_exp(376, {12'hF5F, 12'hFFF}, 2'b00);

    wait_until(405);
    #2;
    seg   = 1;
    rst_n = 1'b0;
    ptype[0] = 3; btn[0] = 12'h242;
    ptype[1] = 1; btn[1] = 12'h021;
    push_exp(40, {12'hFDE, 12'hDBD}, 2'b01);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;

    wait_until(60);
    done = 1'b1;
  end

endmodule
